// File: rtl/mips_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO, one step per cycle.
// Optional signed MULT/DIV support is enabled with `define MIPS_MULDIV_SIGNED_EN.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       AluOP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_MULTU = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MIPS_MULDIV_SIGNED_EN
  localparam logic [3:0] OP_MULT  = 4'd13;
  localparam logic [3:0] OP_DIV   = 4'd14;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + (2*WIDTH)'(1);
  endfunction
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_accept;
  logic                 w_is_div;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]     w_hi_res;
  logic [WIDTH-1:0]     w_lo_res;
`ifdef MIPS_MULDIV_SIGNED_EN
  logic                 w_neg_q;
  logic                 w_neg_r;
  logic                 r_neg_q;
  logic                 r_neg_r;
`endif

  // Opcode decode; signed ops are reduced to magnitudes for the unsigned core
  always_comb begin
    w_accept = 1'b0;
    w_is_div = 1'b0;
    w_a      = X;
    w_b      = Y;
`ifdef MIPS_MULDIV_SIGNED_EN
    w_neg_q  = 1'b0;
    w_neg_r  = 1'b0;
`endif
    case (AluOP)
      OP_MULTU: w_accept = 1'b1;
      OP_DIVU: begin
        w_accept = 1'b1;
        w_is_div = 1'b1;
      end
`ifdef MIPS_MULDIV_SIGNED_EN
      OP_MULT: begin
        w_accept = 1'b1;
        w_a      = X[WIDTH-1] ? neg_w(X) : X;
        w_b      = Y[WIDTH-1] ? neg_w(Y) : Y;
        w_neg_q  = X[WIDTH-1] ^ Y[WIDTH-1];
      end
      OP_DIV: begin
        w_accept = 1'b1;
        w_is_div = 1'b1;
        w_a      = X[WIDTH-1] ? neg_w(X) : X;
        w_b      = Y[WIDTH-1] ? neg_w(Y) : Y;
        // Divide by zero keeps the all-ones quotient unsigned-looking
        w_neg_q  = (X[WIDTH-1] ^ Y[WIDTH-1]) && (Y != {WIDTH{1'b0}});
        w_neg_r  = X[WIDTH-1];
      end
`endif
      default: w_accept = 1'b0;
    endcase
  end

  // One shift-add or restoring-divide step on the accumulator
  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    w_qbit   = ~w_diff[WIDTH];
    if (r_is_div) begin
      w_acc_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};
    end else begin
      w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // Final result with optional sign fix-up, loaded into HI/LO on entry to DONE
  always_comb begin
    w_hi_res = w_acc_nxt[2*WIDTH-1:WIDTH];
    w_lo_res = w_acc_nxt[WIDTH-1:0];
`ifdef MIPS_MULDIV_SIGNED_EN
    if (r_is_div) begin
      if (r_neg_q) begin
        w_lo_res = neg_w(w_acc_nxt[WIDTH-1:0]);
      end else begin
        w_lo_res = w_acc_nxt[WIDTH-1:0];
      end
      if (r_neg_r) begin
        w_hi_res = neg_w(w_acc_nxt[2*WIDTH-1:WIDTH]);
      end else begin
        w_hi_res = w_acc_nxt[2*WIDTH-1:WIDTH];
      end
    end else if (r_neg_q) begin
      {w_hi_res, w_lo_res} = neg_2w(w_acc_nxt);
    end else begin
      {w_hi_res, w_lo_res} = w_acc_nxt;
    end
`endif
  end

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_accept) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_is_div <= 1'b0;
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
`ifdef MIPS_MULDIV_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      if (r_state == S_IDLE && start && w_accept) begin
        r_cnt    <= {CW{1'b0}};
        r_is_div <= w_is_div;
        r_b      <= w_is_div ? w_b : w_a;
        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a : w_b)};
`ifdef MIPS_MULDIV_SIGNED_EN
        r_neg_q  <= w_neg_q;
        r_neg_r  <= w_neg_r;
`endif
      end else if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
